regfile_sb: RTL
===============

# regfile_sb

Parametrised, pipelined register file for the RISC datapath's decode stage. It provides synchronous read with one-cycle latency, write-to-read bypass and operand source muxes with a fully defined select encoding. A per-register pending-write scoreboard raises a stall when a decode-stage read would observe a stale value. It replaces the combinational-read register file and sits between decode and the ID/EX pipeline register.

## Interface
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads zero, ignores writes and is never pending
- clk  in  1  clock, rising-edge
- rst_n  in  1  reset, synchronous, active-low
- wb_en  in  1  writeback strobe
- wb_addr  in  ADDR_W  writeback register address
- wb_data  in  DATA_W  writeback data
- iss_en  in  1  an instruction is issuing from decode this cycle
- iss_wr  in  1  the issuing instruction will write a register
- iss_dst  in  ADDR_W  destination of the issuing instruction
- rd_en  in  1  capture operands this cycle
- aa, ba  in  ADDR_W  source register addresses for A and B
- sel_a, sel_b  in  2  source select: 00 = register, 01 = alt, 10 = fwd, 11 = zero
- pc_1  in  DATA_W  alt source for A
- const_b  in  DATA_W  alt source for B
- fwd  in  DATA_W  forwarded execute result
- bus_a, bus_b  out  DATA_W  registered operands
- stall  out  1  combinational hazard flag; decode must hold

## Operation
- Storage: 2**ADDR_W x DATA_W flops. A write on a clk edge when `wb_en`=1 and `wb_addr` is not zero-guarded.
- Register read value `rv(x)`:
  - 0 if ZERO_REG and x=0.
  - Else `wb_data` if `wb_en` and `wb_addr`=x (same-cycle bypass).
  - Else the stored value.
- Operand value: mux by `sel`. 00 → `rv(addr)`; 01 → `pc_1` (A) / `const_b` (B); 10 → `fwd`; 11 → 0. No select value leaves an output undefined.
- Scoreboard: one `pending` bit per register.
  - Set on an edge with `iss_en && iss_wr && !stall` for `iss_dst`.
  - Cleared on an edge with `wb_en` for `wb_addr`.
  - When set and clear hit the same register on the same edge, set wins.
  - `pending[0]` is constant 0 when ZERO_REG=1.
- Hazard: `haz_a = (sel_a==00) && pending[aa] && !(wb_en && wb_addr==aa)`; `haz_b` is defined likewise for B.
- `stall = rd_en && (haz_a || haz_b)`.
- Operand capture: on an edge with `rd_en && !stall`, load `bus_a`/`bus_b` from the operand muxes. Otherwise hold.
- An `iss_en` with `stall`=1 is ignored; the decoder retries next cycle.

## Timing
- Reset: while `rst_n`=0 at an edge, all registers, all `pending` bits, `bus_a` and `bus_b` become 0. `stall` is 0 the cycle after reset. Reset asserted mid-operation discards all pending writes.
- Write-to-storage latency: 1 edge.
- Read latency: operands appear on `bus_a`/`bus_b` 1 edge after `rd_en`. A same-cycle writeback to the read address is visible with no extra delay.
- `stall` is combinational from `rd_en`, `aa`, `ba`, `sel`, `wb_*` and `pending`. It has no dependence on `iss_*`.
- Back-to-back writes to one register: the last one wins. Writes to register 0 under ZERO_REG=1 have no effect and do not clear or set anything.
- `wb_en` to a register that is not pending is legal: storage updates and pending stays 0.

## Test plan
- Reset and read: reset, then `rd_en` with aa=3, ba=7, sel=00 → next cycle bus_a=0, bus_b=0, stall=0 throughout.
- Bypass: wb_en, wb_addr=5, wb_data=0xDEADBEEF in the same cycle as rd_en, aa=5 → next cycle bus_a=0xDEADBEEF; a later read of r5 also returns 0xDEADBEEF.
- Zero register: write 0x1234 to r0, read aa=0, sel_a=00 → bus_a=0. Issue with iss_dst=0 → no stall on a later read of r0.
- Hazard: issue iss_dst=9; next cycle rd_en with ba=9, sel_b=00 → stall=1 and bus_b holds. Then wb_en to r9 with 0x55 → stall=0 that cycle and bus_b=0x55 next cycle. Repeat with sel_b=10 → no stall, bus_b=fwd.
- Select encodings: sel_a=01, 10, 11 with pc_1=0x100, fwd=0xABC → bus_a=0x100, 0xABC, 0 on successive cycles. sel_b=01 with const_b=0x7F → bus_b=0x7F.
- Set/clear collision and reset mid-op:
  - Set/clear collision: wb_en to r4 and issue iss_dst=4 on the same edge → pending[4] stays 1, so a read of r4 stalls.
  - Reset mid-op: assert rst_n=0 while r4 is pending → after reset a read of r4 gives stall=0 and bus=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Decode-stage register file: synchronous 1-cycle read with writeback bypass,
// operand source muxes and a per-register pending-write scoreboard that stalls stale reads.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_en,
  input  logic              iss_wr,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] aa,
  input  logic [ADDR_W-1:0] ba,
  input  logic [1:0]        sel_a,
  input  logic [1:0]        sel_b,
  input  logic [DATA_W-1:0] pc_1,
  input  logic [DATA_W-1:0] const_b,
  input  logic [DATA_W-1:0] fwd,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b,
  output logic              stall
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pending;
  logic                         wb_ok, iss_set;
  logic                         haz_a, haz_b;
  logic [DATA_W-1:0]            rv_a, rv_b, opnd_a, opnd_b;

  function automatic logic is_zero(input logic [ADDR_W-1:0] x);
    return ZERO_REG && (x == '0);
  endfunction

  // Register 0 under ZERO_REG never stores, never sets or clears pending.
  assign wb_ok   = wb_en && !is_zero(wb_addr);
  assign iss_set = iss_en && iss_wr && !stall && !is_zero(iss_dst);

  always_comb begin
    rv_a = regs[aa];
    if (is_zero(aa))                  rv_a = '0;
    else if (wb_en && wb_addr == aa)  rv_a = wb_data;
    rv_b = regs[ba];
    if (is_zero(ba))                  rv_b = '0;
    else if (wb_en && wb_addr == ba)  rv_b = wb_data;
  end

  always_comb begin
    unique case (sel_a)
      2'b00:   opnd_a = rv_a;
      2'b01:   opnd_a = pc_1;
      2'b10:   opnd_a = fwd;
      default: opnd_a = '0;
    endcase
    unique case (sel_b)
      2'b00:   opnd_b = rv_b;
      2'b01:   opnd_b = const_b;
      2'b10:   opnd_b = fwd;
      default: opnd_b = '0;
    endcase
  end

  // A same-cycle writeback to the source resolves the hazard through the bypass.
  assign haz_a = (sel_a == 2'b00) && pending[aa] && !(wb_en && wb_addr == aa);
  assign haz_b = (sel_b == 2'b00) && pending[ba] && !(wb_en && wb_addr == ba);
  assign stall = rd_en && (haz_a || haz_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs    <= '0;
      pending <= '0;
      bus_a   <= '0;
      bus_b   <= '0;
    end else begin
      if (wb_ok) begin
        regs[wb_addr]    <= wb_data;
        pending[wb_addr] <= 1'b0;
      end
      // Issued after the clear so a same-edge set/clear collision leaves the bit set.
      if (iss_set) pending[iss_dst] <= 1'b1;
      if (rd_en && !stall) begin
        bus_a <= opnd_a;
        bus_b <= opnd_b;
      end
    end
  end
endmodule
